// File: rtl/tsd_responder.sv
// Emulated temperature-sensing diode responder: captures a raw code, waits a settle
// period, then resolves it MSB-first with an 8-step successive-approximation search.
module tsd_responder #(
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter bit          CE_POL        = 1'b1,
  parameter bit          CLR_POL       = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ce,
  input  logic        clr,
  input  logic [7:0]  temp_code,
  output logic [7:0]  tsdcalo,
  output logic        tsdcaldone,
  output logic        busy,
  output logic [15:0] conv_count
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAR    = 2'd2,
    DONE   = 2'd3
  } state_e;

  localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);

  state_e      state_q;
  logic [7:0]  code_q;
  logic [7:0]  result_q;
  logic [7:0]  settle_q;
  logic [2:0]  bit_q;
  logic        clr_q;
  logic [7:0]  tsdcalo_q;
  logic        done_q;
  logic        busy_q;
  logic [15:0] count_q;

  logic        ce_eff;
  logic        clr_eff;
  logic [7:0]  trial_d;
  logic [7:0]  result_d;

  assign ce_eff  = (ce == CE_POL);
  assign clr_eff = (clr == CLR_POL);

  // Keep the trial bit only if the candidate does not overshoot the captured code.
  always_comb begin
    trial_d  = result_q | (8'd1 << bit_q);
    result_d = (trial_d <= code_q) ? trial_d : result_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      code_q    <= 8'd0;
      result_q  <= 8'd0;
      settle_q  <= 8'd0;
      bit_q     <= 3'd0;
      clr_q     <= 1'b0;
      tsdcalo_q <= 8'd0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      count_q   <= 16'd0;
    end else begin
      clr_q <= clr_eff;
      if (clr_eff) begin
        state_q   <= IDLE;
        done_q    <= 1'b0;
        busy_q    <= 1'b0;
        tsdcalo_q <= 8'd0;
      end else begin
        case (state_q)
          IDLE: begin
            // A start needs the falling edge of a clear pulse seen while enabled.
            if (clr_q && ce_eff) begin
              code_q   <= temp_code;
              result_q <= 8'd0;
              settle_q <= SETTLE_LOAD;
              state_q  <= SETTLE;
              busy_q   <= 1'b1;
            end
          end
          SETTLE: begin
            if (ce_eff) begin
              if (settle_q == 8'd0) begin
                state_q <= SAR;
                bit_q   <= 3'd7;
              end else begin
                settle_q <= settle_q - 8'd1;
              end
            end
          end
          SAR: begin
            if (ce_eff) begin
              result_q <= result_d;
              if (bit_q == 3'd0) begin
                state_q   <= DONE;
                tsdcalo_q <= result_d;
                done_q    <= 1'b1;
                busy_q    <= 1'b0;
                count_q   <= count_q + 16'd1;
              end else begin
                bit_q <= bit_q - 3'd1;
              end
            end
          end
          DONE: begin
            state_q <= DONE;
          end
          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign tsdcalo    = tsdcalo_q;
  assign tsdcaldone = done_q;
  assign busy       = busy_q;
  assign conv_count = count_q;

endmodule

// File: tb/tb_tsd_responder.sv
// Scoreboard bench for tsd_responder: a default instance plus an inverted-polarity,
// single-settle-cycle instance, sharing one clock and reset.
module tb_tsd_responder;

  logic        clk;
  logic        rst_n;
  logic        ce0, clr0, ce1, clr1;
  logic [7:0]  temp0, temp1;
  logic [7:0]  tsdcalo0, tsdcalo1;
  logic        done0, done1, busy0, busy1;
  logic [15:0] count0, count1;

  int          checkCount = 0;
  int          errorCount = 0;
  int          edgeCount = 0;
  int          eEdge = 0;
  logic [7:0]  scoreboard[$];

  tsd_responder dut0 (
    .clk(clk), .rst_n(rst_n), .ce(ce0), .clr(clr0), .temp_code(temp0),
    .tsdcalo(tsdcalo0), .tsdcaldone(done0), .busy(busy0), .conv_count(count0)
  );

  tsd_responder #(.SETTLE_CYCLES(1), .CE_POL(1'b0), .CLR_POL(1'b0)) dut1 (
    .clk(clk), .rst_n(rst_n), .ce(ce1), .clr(clr1), .temp_code(temp1),
    .tsdcalo(tsdcalo1), .tsdcaldone(done1), .busy(busy1), .conv_count(count1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
    end
  endtask

  // One rising edge, then settle 1 time unit so outputs are sampled away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    edgeCount++;
  endtask

  // Pulse clr on the default instance; the deassertion edge is the start edge E.
  task automatic applyStimulus(input logic [7:0] code);
    clr0 = 1'b1;
    tick();
    clr0  = 1'b0;
    temp0 = code;
    tick();
    eEdge = edgeCount;
    scoreboard.push_back(code);
    checkOutput("busyAfterStart", busy0, 1'b1);
  endtask

  task automatic waitDone(input bit which, input int expLatency, input int budget);
    bit         found;
    logic [7:0] expected;
    found = 1'b0;
    while (edgeCount - eEdge < budget) begin
      tick();
      if ((which ? done1 : done0) == 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    checkOutput("doneSeen", found, 1'b1);
    expected = scoreboard.pop_front();
    if (found) begin
      checkOutput("latency", edgeCount - eEdge, expLatency);
      checkOutput("result", which ? tsdcalo1 : tsdcalo0, expected);
      checkOutput("busyAtDone", which ? busy1 : busy0, 1'b0);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    ce0 = 1'b1; clr0 = 1'b0; temp0 = 8'd0;
    ce1 = 1'b1; clr1 = 1'b1; temp1 = 8'd0;
    repeat (3) tick();
    checkOutput("rstTsdcalo", tsdcalo0, 8'd0);
    checkOutput("rstDone", done0, 1'b0);
    checkOutput("rstBusy", busy0, 1'b0);
    checkOutput("rstCount", count0, 16'd0);
    checkOutput("rstDone1", done1, 1'b0);

    rst_n = 1'b1;
    repeat (3) tick();
    checkOutput("idleNoClr", busy0, 1'b0);

    // Basic conversion with ce held active.
    applyStimulus(8'd158);
    waitDone(1'b0, 24, 60);
    checkOutput("count1", count0, 16'd1);
    repeat (4) tick();
    checkOutput("doneHeld", done0, 1'b1);
    checkOutput("resultHeld", tsdcalo0, 8'd158);

    // Clear out of DONE, then a conversion frozen for 10 cycles mid-SAR.
    clr0 = 1'b1;
    tick();
    checkOutput("clrDone", done0, 1'b0);
    checkOutput("clrTsdcalo", tsdcalo0, 8'd0);
    checkOutput("clrCount", count0, 16'd1);
    clr0 = 1'b0;
    temp0 = 8'h5A;
    tick();
    eEdge = edgeCount;
    scoreboard.push_back(8'h5A);
    checkOutput("busyAfterStart", busy0, 1'b1);
    repeat (18) tick();
    ce0 = 1'b0;
    repeat (10) tick();
    checkOutput("frozenBusy", busy0, 1'b1);
    checkOutput("frozenTsdcalo", tsdcalo0, 8'd0);
    ce0 = 1'b1;
    waitDone(1'b0, 34, 80);
    checkOutput("count2", count0, 16'd2);

    // Abort with clr at E+20.
    applyStimulus(8'h40);
    repeat (19) tick();
    clr0 = 1'b1;
    tick();
    void'(scoreboard.pop_back());
    checkOutput("abortDone", done0, 1'b0);
    checkOutput("abortTsdcalo", tsdcalo0, 8'd0);
    checkOutput("abortBusy", busy0, 1'b0);
    tick();
    checkOutput("clrHeldIdle", busy0, 1'b0);
    checkOutput("abortCount", count0, 16'd2);

    // Next pulse completes; the code changes at E+3 must not matter.
    applyStimulus(8'h85);
    tick();
    tick();
    temp0 = 8'h20;
    waitDone(1'b0, 24, 60);
    checkOutput("count3", count0, 16'd3);

    // Reset during SETTLE discards the conversion.
    applyStimulus(8'h33);
    repeat (5) tick();
    rst_n = 1'b0;
    tick();
    void'(scoreboard.pop_back());
    checkOutput("midRstTsdcalo", tsdcalo0, 8'd0);
    checkOutput("midRstDone", done0, 1'b0);
    checkOutput("midRstBusy", busy0, 1'b0);
    checkOutput("midRstCount", count0, 16'd0);
    rst_n = 1'b1;
    repeat (5) tick();
    checkOutput("noStartAfterRst", busy0, 1'b0);

    // Inverted polarities: ce = 1 is inactive, so a clr pulse must not start it.
    clr1 = 1'b0;
    tick();
    clr1 = 1'b1;
    temp1 = 8'hFF;
    repeat (5) tick();
    checkOutput("ceInactiveBusy", busy1, 1'b0);
    checkOutput("ceInactiveDone", done1, 1'b0);
    ce1 = 1'b0;
    clr1 = 1'b0;
    tick();
    clr1 = 1'b1;
    tick();
    eEdge = edgeCount;
    scoreboard.push_back(8'hFF);
    checkOutput("busy1AfterStart", busy1, 1'b1);
    waitDone(1'b1, 9, 40);
    checkOutput("count1Inv", count1, 16'd1);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule

// File: doc/tsd_responder.md
TSD_RESPONDER -- requirements
Module: tsd_responder

Interface
REQ-001 Parameter SETTLE_CYCLES, default 16: number of enabled cycles between conversion start and the first SAR bit decision; legal range 1..255.
REQ-002 Parameter CE_POL, default 1: active level of ce (1 = active-high, 0 = active-low).
REQ-003 Parameter CLR_POL, default 1: active level of clr (1 = active-high, 0 = active-low).
REQ-004 Port clk  input  1  the single clock; all state updates occur on the rising edge.
REQ-005 Port rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-006 Port ce  input  1  conversion enable, polarity set by CE_POL.
REQ-007 Port clr  input  1  clear/start control, polarity set by CLR_POL.
REQ-008 Port temp_code  input  8  emulated raw sensor code; code = degrees C + 133.
REQ-009 Port tsdcalo  output  8  conversion result.
REQ-010 Port tsdcaldone  output  1  conversion complete; tsdcalo valid while high.
REQ-011 Port busy  output  1  high in SETTLE and SAR states.
REQ-012 Port conv_count  output  16  number of completed conversions; wraps from 0xFFFF to 0x0000.

Function
REQ-013 Definitions: ce_eff = (ce == CE_POL); clr_eff = (clr == CLR_POL); clr_q = clr_eff registered on each clk edge.
REQ-014 FSM states: IDLE, SETTLE, SAR, DONE. Outputs: busy = SETTLE or SAR; tsdcaldone = DONE.
REQ-015 Start edge E: the first edge where state is IDLE, clr_q = 1, clr_eff = 0 and ce_eff = 1.
REQ-016 At E: capture temp_code into code_s, clear the result register to 0, load settle_cnt = SETTLE_CYCLES-1, and enter SETTLE.
REQ-017 SETTLE: on each edge with ce_eff = 1, if settle_cnt == 0, enter SAR with bit index 7; otherwise decrement settle_cnt.
REQ-018 SAR: on each edge with ce_eff = 1, resolve bit i (starting from 7): set result[i] = 1 if (result | 1<<i) <= code_s; otherwise result[i] = 0. Then decrement i.
REQ-019 After bit 0 is resolved, enter DONE on that same edge: tsdcalo = result = code_s, conv_count increments by 1, and tsdcaldone = 1.
REQ-020 Latency with ce held active: tsdcaldone first reads 1 after edge E + SETTLE_CYCLES + 8.
REQ-021 ce_eff = 0 freezes the SETTLE and SAR states and all counters; a start edge cannot occur while ce_eff = 0.
REQ-022 DONE persists, with tsdcalo and tsdcaldone held, until clr_eff = 1.
REQ-023 clr_eff = 1 dominates in any state, regardless of ce_eff. On that edge: state becomes IDLE, tsdcaldone = 0, busy = 0, and tsdcalo = 0. conv_count is unchanged.
REQ-024 A clear during SETTLE or SAR aborts the conversion: conv_count does not increment and no partial result appears on tsdcalo.
REQ-025 While clr stays asserted, the block remains in IDLE; a start requires a deassertion edge (REQ-015).
REQ-026 temp_code changes after E do not affect the result in progress.
REQ-027 temp_code = 0xFF converts to 0xFF; the block reports it unmodified, with no saturation.
REQ-028 tsdcalo changes only on entry to DONE or on a clear/reset; it is stable at every other time.

Reset
REQ-029 When rst_n = 0 at an edge: state = IDLE, tsdcalo = 0x00, tsdcaldone = 0, busy = 0, conv_count = 0, clr_q = 0, and internal counters = 0.
REQ-030 Reset overrides clr and ce on the same edge.
REQ-031 Reset applied mid-conversion discards the conversion without incrementing conv_count.
REQ-032 After rst_n returns high, a conversion requires a fresh assertion and deassertion of clr.

Verification
REQ-033 Default parameters, temp_code = 158, one-cycle clr pulse, ce held high -> busy high from E+1; tsdcaldone rises after edge E+24; tsdcalo = 158; conv_count = 1.
REQ-034 ce low for 10 cycles during SAR -> tsdcaldone rises after edge E+34; tsdcalo matches the captured code.
REQ-035 clr asserted at E+20 -> tsdcaldone stays 0, tsdcalo = 0, conv_count unchanged; the next pulse completes normally.
REQ-036 CE_POL = 0, CLR_POL = 0, SETTLE_CYCLES = 1, temp_code = 0xFF -> done after edge E+9 with tsdcalo = 0xFF. With ce = 1 the block never starts.
REQ-037 temp_code changed from 0x85 to 0x20 at E+3 -> result = 0x85.
REQ-038 65536 back-to-back conversions -> conv_count wraps to 0. rst_n low during SETTLE -> all outputs read zero on the next cycle.
